// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score display slice.
//   conv_state_t  : converter FSM states (IDLE, SHIFT, DONE)
//   NUM_DIGITS    : number of BCD digits shown (5)
//   SEG_*         : active-high 7-segment patterns, bit 0 = a .. bit 6 = g
//   digit_to_seg  : BCD digit -> segment pattern (non-decimal codes blank)
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned SRC_W      = 16;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 16-bit binary to 5-digit BCD converter (double dabble).
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   start in   accepted only in IDLE; captures bin
//   bin   in   16-bit binary value
//   bcd   out  last completed result, held between conversions
//   busy  out  high during the 16 shift cycles and the DONE cycle
// Start accepted at edge N: iterations on edges N+1..N+16, bcd loads at N+17.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SRC_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  conv_state_t                state, state_next;
  logic [BCD_W+SRC_W-1:0]     shreg;
  logic [BCD_W+SRC_W-1:0]     shreg_adj;
  logic [3:0]                 iter;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (iter == 4'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    shreg_adj = shreg;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (shreg[SRC_W + 4*i +: 4] >= 4'd5)
        shreg_adj[SRC_W + 4*i +: 4] = shreg[SRC_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      iter  <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      // Registered so busy rises one edge after the capture edge and
      // falls on the edge that publishes the result.
      busy  <= (state == SHIFT);
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= {{BCD_W{1'b0}}, bin};
            iter  <= '0;
          end
        end
        SHIFT: begin
          shreg <= {shreg_adj[BCD_W+SRC_W-2:0], 1'b0};
          iter  <= iter + 4'd1;
        end
        DONE:    bcd <= shreg[BCD_W+SRC_W-1:SRC_W];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// score_display: converts the game score to BCD once per frame and drives a
// multiplexed 5-digit 7-segment display with leading-zero blanking.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   score     in   16-bit binary score
//   game_tick in   frame pulse; starts a conversion when the converter is idle
//   game_over in   end-of-game pulse (high-score update)
//   show_hi   in   1 = convert the high score instead of score
//   bcd       out  last converted value, digit 0 in [3:0]
//   busy      out  conversion in progress
//   seg       out  active-high segments a..g on [0]..[6]
//   dig_en    out  one-hot digit enable, bit 0 = least significant digit
// Parameter SCAN_DIV: clock cycles each digit stays enabled (>= 2).
// Macro SCORE_HISCORE_EN: adds the high-score register; without it show_hi
// and game_over are ignored and score is always converted.
module score_display
  import score_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SRC_W-1:0]      score,
  input  logic                  game_tick,
  input  logic                  game_over,
  input  logic                  show_hi,
  output logic [BCD_W-1:0]      bcd,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SRC_W-1:0] src;

`ifdef SCORE_HISCORE_EN
  logic [SRC_W-1:0] hi_score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hi_score <= '0;
    else if (game_over && (score > hi_score))
      hi_score <= score;
  end

  // The converter captures on the same edge hi_score updates, so a
  // simultaneous game_over/game_tick converts the old high score.
  assign src = show_hi ? hi_score : score;
`else
  logic unused_cfg;
  assign unused_cfg = show_hi ^ game_over;
  assign src        = score;
`endif

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (game_tick),
    .bin   (src),
    .bcd   (bcd),
    .busy  (busy)
  );

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       dig_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : dig_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [2:0] msd_idx;
  logic [3:0] cur_digit;

  always_comb begin
    msd_idx   = '0;
    cur_digit = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd_idx = 3'(i);
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == 3'(i)) cur_digit = bcd[4*i +: 4];
    end
  end

  always_comb begin
    dig_en = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == 3'(i)) dig_en[i] = 1'b1;
    end
    seg = (dig_idx > msd_idx) ? SEG_BLANK : digit_to_seg(cur_digit);
  end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] score;
  logic        game_tick;
  logic        game_over;
  logic        show_hi;
  logic [19:0] bcd;
  logic        busy;
  logic [6:0]  seg;
  logic [4:0]  dig_en;

  int          checks = 0;
  int          errors = 0;
  int unsigned ncyc   = 0;
  logic [19:0] exp_bcd = '0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  score_display #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .score     (score),
    .game_tick (game_tick),
    .game_over (game_over),
    .show_hi   (show_hi),
    .bcd       (bcd),
    .busy      (busy),
    .seg       (seg),
    .dig_en    (dig_en)
  );

  always #5 clk = ~clk;

  // Clock cycles since reset release; selects the digit the display should show.
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc = 0;
    else     ncyc = ncyc + 1;
  end

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned d;
    d = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [19:0] b, input int idx);
    int unsigned n;
    int unsigned p;
    n = 0;
    for (int k = 4; k >= 0; k--) n = n * 10 + int'(b[4*k +: 4]);
    p = 1;
    for (int j = 0; j < idx; j++) p = p * 10;
    if (idx != 0 && n < p) return 7'h00;
    return seg_tab[b[4*idx +: 4]];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_disp();
    int idx;
    idx = int'((ncyc / SD) % 5);
    check("dig_en", {27'd0, dig_en}, 32'd1 << idx);
    check("seg", {25'd0, seg}, {25'd0, exp_seg(exp_bcd, idx)});
  endtask

  task automatic convert(input logic [15:0] v, input logic [19:0] expv, input bit extra_tick);
    score     = v;
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    check("busy_edgeN", {31'd0, busy}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if (extra_tick && i == 5) game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      score = 16'($urandom);
      check("busy_shift", {31'd0, busy}, 32'd1);
      check("bcd_hold", {12'd0, bcd}, {12'd0, exp_bcd});
    end
    step();
    exp_bcd = expv;
    check("bcd_result", {12'd0, bcd}, {12'd0, exp_bcd});
    check("busy_done", {31'd0, busy}, 32'd0);
    check_disp();
    if (extra_tick) begin
      for (int i = 0; i < 3; i++) begin
        step();
        check("busy_no_requeue", {31'd0, busy}, 32'd0);
        check("bcd_no_requeue", {12'd0, bcd}, {12'd0, exp_bcd});
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    rst       = 1'b1;
    score     = '0;
    game_tick = 1'b0;
    game_over = 1'b0;
    show_hi   = 1'b0;
    step();
    step();
    check("rst_bcd", {12'd0, bcd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dig_en", {27'd0, dig_en}, 32'h01);
    check("rst_seg", {25'd0, seg}, 32'h3F);
    rst = 1'b0;

    convert(16'd12345, to_bcd(12345), 1'b0);
    convert(16'd65535, to_bcd(65535), 1'b0);
    convert(16'd0, to_bcd(0), 1'b0);
    convert(16'd9876, to_bcd(9876), 1'b1);

    // Scan walk over two full rotations with a two-digit value.
    convert(16'd42, to_bcd(42), 1'b0);
    for (int i = 0; i < 2 * 5 * SD; i++) begin
      step();
      check_disp();
    end

    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom_range(0, 65535));
      convert(v, to_bcd(int'(v)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(1, 7)); j++) begin
        step();
        check_disp();
      end
    end

`ifdef SCORE_HISCORE_EN
    score = 16'd500;  game_over = 1'b1; step();
    score = 16'd300;  step();
    game_over = 1'b0;
    show_hi   = 1'b1;
    convert(16'd123, to_bcd(500), 1'b0);
    show_hi   = 1'b0;
`else
    game_over = 1'b1;
    show_hi   = 1'b1;
    convert(16'd777, to_bcd(777), 1'b0);
    game_over = 1'b0;
    show_hi   = 1'b0;
`endif

    // Reset eight cycles into a conversion: abort, no late update.
    score     = 16'd4321;
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    #1;
    exp_bcd = '0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_bcd", {12'd0, bcd}, 32'd0);
    check("midrst_dig_en", {27'd0, dig_en}, 32'h01);
    check("midrst_seg", {25'd0, seg}, 32'h3F);
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("postrst_bcd", {12'd0, bcd}, 32'd0);
      check("postrst_busy", {31'd0, busy}, 32'd0);
    end
    check_disp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1000, meaning clock cycles each digit stays enabled (minimum 2).
REQ-002 SHALL provide port clk  in  1  single system clock; all state on rising edge.
REQ-003 SHALL provide port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL provide port score  in  16  binary game score from the score counter.
REQ-005 SHALL provide port game_tick  in  1  one-cycle end-of-frame pulse, 60 Hz; starts a conversion.
REQ-006 SHALL provide port game_over  in  1  one-cycle pulse marking end of game.
REQ-007 SHALL provide port show_hi  in  1  level; 1 selects the high score as the conversion source.
REQ-008 SHALL provide port bcd  out  20  last converted value, 5 BCD digits, digit 0 in [3:0].
REQ-009 SHALL provide port busy  out  1  conversion in progress.
REQ-010 SHALL provide port seg  out  7  active-high segments, seg[0]=a .. seg[6]=g.
REQ-011 SHALL provide port dig_en  out  5  one-hot active-high digit enable, bit 0 = least significant digit.

Function
REQ-012 Converter FSM SHALL have states IDLE, SHIFT, DONE.
REQ-013 In IDLE, game_tick=1 at edge N SHALL capture the source (score, or high score when selected) and enter SHIFT.
REQ-014 SHIFT SHALL run exactly 16 double-dabble iterations: add 3 to each nibble >=5, then shift left one bit.
REQ-015 After the 16th iteration the FSM SHALL enter DONE; bcd SHALL update at edge N+17 and the FSM return to IDLE.
REQ-016 busy SHALL be 1 from edge N+1 until edge N+17, otherwise 0.
REQ-017 game_tick while busy SHALL be ignored (dropped, not queued).
REQ-018 bcd SHALL hold its value between conversions and SHALL never show partial results.
REQ-019 Scan counter SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0,1,2,3,4,0.
REQ-020 dig_en SHALL be the one-hot decode of the digit index.
REQ-021 seg SHALL be the decoded bcd digit at the current index: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-022 Leading-zero blanking: seg SHALL be 0x00 for digits above the most significant nonzero digit; digit 0 SHALL always display.

Reset
REQ-023 rst=1 SHALL immediately force the following values: FSM IDLE, busy 0, bcd 0, scan counter 0, dig_en 5'b00001, seg 0x3F, high score 0.
REQ-024 rst asserted mid-conversion SHALL abort it; no bcd update SHALL follow.

Configuration
REQ-025 Macro SCORE_HISCORE_EN SHALL compile in a 16-bit high-score register.
REQ-026 With the macro defined, game_over SHALL load high score <= score when score > high score; it SHALL be cleared only by rst.
REQ-027 With the macro defined, game_over and game_tick in the same cycle SHALL both act; the conversion SHALL capture the pre-update high score.
REQ-028 Without the macro, the high-score register SHALL be absent, show_hi and game_over SHALL be ignored, and the source SHALL always be score.

Structure
REQ-029 Package score_pkg SHALL hold:
- the FSM state enum
- NUM_DIGITS=5
- the 7-segment constants and the digit-to-segment decode function
REQ-030 Sub-module bin2bcd_seq SHALL contain the FSM, shift register and busy flag; score_display SHALL contain the scan logic, blanking logic and high-score register.

Verification
REQ-031 Reset: assert rst -> bcd=0, busy=0, dig_en=00001, seg=0x3F.
REQ-032 Latency: score=12345, tick at edge N -> busy 1 for edges N+1..N+16; bcd=0x12345 at N+17.
REQ-033 Extremes:
- score=65535 -> bcd=0x65535
- score=0 -> bcd=0x00000
- second tick during busy -> result unaffected, no extra conversion
REQ-034 Scan: SCAN_DIV=4, bcd=0x00042 -> dig_en steps 00001,00010,00100,01000,10000 every 4 cycles; seg shows 0x5B, 0x66, then 0x00 three times.
REQ-035 High score (macro defined):
- game_over with score=500, then with score=300
- show_hi=1 plus tick -> bcd=0x00500
REQ-036 Reset mid-operation: rst at cycle 8 of a conversion -> busy=0 and bcd=0 immediately; no update at N+17.
